// File: rtl/mapu_engine.sv
// Matrix APU core: loads 3x3 A then B as row beats and returns A+B or A*B as three row beats plus an overflow flag.
// Latency: o_vld rises 2 cycles (add) or 4 cycles (multiply) after the last B beat is accepted.
// Backpressure: o_rdy only while loading; an output row is held while i_rdy is low. MAPU_ENGINE_OF_STICKY_EN keeps o_of set until reset.
module mapu_engine #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic                  i_op,
  output logic                  o_of,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_r0,
  input  logic [DATA_WIDTH-1:0] i_r1,
  input  logic [DATA_WIDTH-1:0] i_r2,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_r0,
  output logic [DATA_WIDTH-1:0] o_r1,
  output logic [DATA_WIDTH-1:0] o_r2
);
  localparam int PW = 2 * DATA_WIDTH + 2;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, DRAIN} state_t;

  state_t                state, state_nx;
  logic [1:0]            row_cnt;
  logic [1:0]            row_nx;
  logic                  last_row;
  logic                  op_mul;
  logic                  in_fire;
  logic [DATA_WIDTH-1:0] a_m     [3][3];
  logic [DATA_WIDTH-1:0] b_m     [3][3];
  logic [DATA_WIDTH-1:0] res_m   [3][3];
  logic [DATA_WIDTH-1:0] add_res [3][3];
  logic [DATA_WIDTH-1:0] mul_res [3];
  logic                  add_of;
  logic                  mul_of;

  // Gated by reset_n so the upstream never sees ready while the core is held in reset.
  assign o_rdy    = reset_n && i_en && (state == LOAD_A || state == LOAD_B);
  assign in_fire  = i_vld && o_rdy;
  assign last_row = (row_cnt == 2'd2);
  assign row_nx   = row_cnt + 2'd1;

  always_comb begin : add_calc
    logic [DATA_WIDTH:0] s;
    s      = '0;
    add_of = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s             = {1'b0, a_m[i][j]} + {1'b0, b_m[i][j]};
        add_res[i][j] = s[DATA_WIDTH-1:0];
        add_of        = add_of | s[DATA_WIDTH];
      end
    end
  end

  // One result row per cycle, row selected by row_cnt.
  always_comb begin : mul_calc
    logic [PW-1:0] acc;
    acc    = '0;
    mul_of = 1'b0;
    for (int j = 0; j < 3; j++) begin
      acc = '0;
      for (int k = 0; k < 3; k++) begin
        acc = acc + PW'(a_m[row_cnt][k]) * PW'(b_m[k][j]);
      end
      mul_res[j] = acc[DATA_WIDTH-1:0];
      mul_of     = mul_of | (|acc[PW-1:DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD_A;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD_A:  if (in_fire && last_row) state_nx = LOAD_B;
      LOAD_B:  if (in_fire && last_row) state_nx = COMPUTE;
      COMPUTE: if (!op_mul || last_row) state_nx = DRAIN;
      DRAIN:   if (o_vld && i_rdy && last_row) state_nx = LOAD_A;
      default: state_nx = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt <= '0;
      op_mul  <= 1'b0;
      o_of    <= 1'b0;
      o_vld   <= 1'b0;
      o_r0    <= '0;
      o_r1    <= '0;
      o_r2    <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          a_m[i][j]   <= '0;
          b_m[i][j]   <= '0;
          res_m[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (in_fire) begin
            if (state == LOAD_A) a_m[row_cnt] <= '{i_r0, i_r1, i_r2};
            else                 b_m[row_cnt] <= '{i_r0, i_r1, i_r2};
            if (state == LOAD_A && row_cnt == 2'd0) begin
              op_mul <= i_op;
`ifdef MAPU_ENGINE_OF_STICKY_EN
              o_of   <= o_of;
`else
              o_of   <= 1'b0;
`endif
            end
            row_cnt <= last_row ? 2'd0 : row_nx;
          end
        end
        COMPUTE: begin
          if (op_mul) begin
            res_m[row_cnt] <= mul_res;
            if (mul_of) o_of <= 1'b1;
            row_cnt <= last_row ? 2'd0 : row_nx;
          end else begin
            res_m <= add_res;
            if (add_of) o_of <= 1'b1;
          end
        end
        DRAIN: begin
          // o_vld low on entry marks the cycle that presents row 0.
          if (!o_vld) begin
            o_vld <= 1'b1;
            o_r0  <= res_m[0][0];
            o_r1  <= res_m[0][1];
            o_r2  <= res_m[0][2];
          end else if (i_rdy) begin
            if (last_row) begin
              o_vld   <= 1'b0;
              row_cnt <= 2'd0;
            end else begin
              row_cnt <= row_nx;
              o_r0    <= res_m[row_nx][0];
              o_r1    <= res_m[row_nx][1];
              o_r2    <= res_m[row_nx][2];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mapu_engine.sv
// Scoreboard bench for mapu_engine: directed matrix ops push expected rows and latencies;
// a monitor pops and compares on every output transfer and checks data stability under stall.
module tb_mapu_engine;
`ifdef MAPU_ENGINE_OF_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_en, i_op, i_vld, i_rdy;
  logic [31:0] i_r0, i_r1, i_r2;
  logic        o_of, o_rdy, o_vld;
  logic [31:0] o_r0, o_r1, o_r2;

  typedef struct {
    logic [31:0] r0, r1, r2;
    logic        of;
  } row_t;

  row_t        sb[$];
  int          lat_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_b = 0;
  logic        prev_vld = 1'b0;
  logic        stall_pend = 1'b0;
  logic [95:0] saved = '0;
  logic [31:0] ma[9], mb[9];

  mapu_engine #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_op(i_op), .o_of(o_of),
    .i_vld(i_vld), .o_rdy(o_rdy), .i_r0(i_r0), .i_r1(i_r1), .i_r2(i_r2),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_r0(o_r0), .o_r1(o_r1), .o_r2(o_r2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_row(input logic [31:0] r0, r1, r2, input logic of);
    row_t e;
    e.r0 = r0; e.r1 = r1; e.r2 = r2; e.of = of;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat transfers.
  task automatic send(input logic [31:0] r0, r1, r2, input logic op);
    int n = 0;
    i_vld = 1'b1; i_r0 = r0; i_r1 = r1; i_r2 = r2; i_op = op;
    #1;
    while (!o_rdy && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!o_rdy) begin
      total++; bad++;
      $display("FAIL send_timeout: o_rdy=%0b want 1", o_rdy);
    end
    @(posedge clk); #1 last_b = cyc;
    @(negedge clk);
    i_vld = 1'b0;
  endtask

  task automatic send_mat(input logic op0, input logic op1);
    send(ma[0], ma[1], ma[2], op0);
    send(ma[3], ma[4], ma[5], op1);
    send(ma[6], ma[7], ma[8], op1);
    send(mb[0], mb[1], mb[2], op1);
    send(mb[3], mb[4], mb[5], op1);
    send(mb[6], mb[7], mb[8], op1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: rows_left=%0d want 0", sb.size());
    end
    @(negedge clk); @(negedge clk);
  endtask

  // Monitor: samples just after the falling edge, once stimulus has settled.
  always begin
    row_t e;
    @(negedge clk); #2;
    if (!reset_n) begin
      prev_vld   = 1'b0;
      stall_pend = 1'b0;
    end else begin
      if (o_vld && !prev_vld) begin
        if (lat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vld: o_vld=1 want 0");
        end else begin
          chk("latency", 96'(cyc - last_b), 96'(lat_q.pop_front()));
        end
      end
      if (stall_pend) begin
        chk("stall_vld", 96'(o_vld), 96'(1));
        chk("stall_dat", {o_r0, o_r1, o_r2}, saved);
      end
      stall_pend = o_vld && !i_rdy;
      saved      = {o_r0, o_r1, o_r2};
      if (o_vld && i_rdy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat: got %0h want none", {o_r0, o_r1, o_r2});
        end else begin
          e = sb.pop_front();
          chk("row_r0", 96'(o_r0), 96'(e.r0));
          chk("row_r1", 96'(o_r1), 96'(e.r1));
          chk("row_r2", 96'(o_r2), 96'(e.r2));
          chk("row_of", 96'(o_of), 96'(e.of));
        end
      end
      prev_vld = o_vld;
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; i_en = 1'b1; i_op = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
    i_r0 = '0; i_r1 = '0; i_r2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", 96'(o_rdy), 96'(0));
    chk("rst_vld", 96'(o_vld), 96'(0));
    chk("rst_of",  96'(o_of),  96'(0));
    chk("rst_dat", {o_r0, o_r1, o_r2}, 96'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // add: all 1 + all 2
    ma = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    mb = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
    repeat (3) push_row(3, 3, 3, 1'b0);
    lat_q.push_back(2);
    send_mat(1'b0, 1'b0);
    wait_drain();

    // multiply: identity * B
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    push_row(1, 2, 3, 1'b0); push_row(4, 5, 6, 1'b0); push_row(7, 8, 9, 1'b0);
    lat_q.push_back(4);
    send_mat(1'b1, 1'b1);
    wait_drain();

    // add overflow in element [0][0]
    ma = '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    repeat (3) push_row(0, 0, 0, 1'b1);
    lat_q.push_back(2);
    send_mat(1'b0, 1'b0);
    wait_drain();
    chk("of_hold", 96'(o_of), 96'(1));

    // flow control: i_en stalls loading, i_rdy stalls draining
    push_row(11, 22, 33, STICKY); push_row(44, 55, 66, STICKY); push_row(77, 88, 99, STICKY);
    lat_q.push_back(2);
    send(1, 2, 3, 1'b0);
    chk("of_clear", 96'(o_of), 96'(STICKY));
    send(4, 5, 6, 1'b0);
    i_en = 1'b0; i_vld = 1'b1; i_r0 = 7; i_r1 = 8; i_r2 = 9;
    repeat (5) begin
      @(negedge clk); #1;
      chk("rdy_gated", 96'(o_rdy), 96'(0));
    end
    i_en = 1'b1;
    send(7, 8, 9, 1'b0);
    send(10, 20, 30, 1'b0);
    send(40, 50, 60, 1'b0);
    send(70, 80, 90, 1'b0);
    i_rdy = 1'b0;
    n = 0;
    while (!o_vld && n < 50) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    i_rdy = 1'b1;
    wait_drain();

    // reset during COMPUTE of an overflowing multiply
    ma = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0};
    mb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    send_mat(1'b1, 1'b1);
    @(negedge clk); #1;
    chk("of_pre_rst", 96'(o_of), 96'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", 96'(o_vld), 96'(0));
    chk("mid_rst_of",  96'(o_of),  96'(0));
    chk("mid_rst_rdy", 96'(o_rdy), 96'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // fresh add after reset
    ma = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    mb = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    repeat (3) push_row(2, 2, 2, 1'b0);
    lat_q.push_back(2);
    send_mat(1'b0, 1'b0);
    wait_drain();

    // i_op captured on the first A beat only
    ma = '{1, 2, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    push_row(9, 12, 15, 1'b0); push_row(4, 5, 6, 1'b0); push_row(7, 8, 9, 1'b0);
    lat_q.push_back(4);
    send_mat(1'b1, 1'b0);
    wait_drain();

    chk("lat_left", 96'(lat_q.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
